// File: rtl/act_mux_pipe.sv
// Gated-select word mux (ACT_C2 successor) followed by a 2-stage valid/ready pipeline.
// Optional even-parity output enabled by defining ACT_MUX_PARITY_EN.
module act_mux_pipe #(
    parameter int                XLEN      = 8,
    parameter int                SEL_W     = 2,
    parameter logic [SEL_W-1:0]  GATE_MASK = 2'b10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [(2**SEL_W)*XLEN-1:0]  in_data,
    input  logic [SEL_W-1:0]            in_a,
    input  logic [SEL_W-1:0]            in_b,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [XLEN-1:0]             out_data,
    output logic                        out_valid,
`ifdef ACT_MUX_PARITY_EN
    output logic                        out_parity,
`endif
    input  logic                        out_ready
);

    localparam int NUM_WORDS = 2**SEL_W;

    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  mux_word;
    logic             v1, v2;
    logic [XLEN-1:0]  d1, d2;
    logic             adv1, adv2;

    // Each select bit is an OR or AND of its A/B pair, chosen by GATE_MASK.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel = '0;
        for (int i = 0; i < SEL_W; i++) begin
            sel[i] = GATE_MASK[i] ? (in_a[i] | in_b[i]) : (in_a[i] & in_b[i]);
        end
    end

    // Full decode: every select value maps to a real word, never to X/Z.
    always_comb begin
        mux_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (sel == SEL_W'(k)) mux_word = in_data[k*XLEN +: XLEN];
        end
    end

    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            if (adv2) begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) d1 <= mux_word;
            end
        end
    end

    assign out_valid = v2;
    assign out_data  = d2;

`ifdef ACT_MUX_PARITY_EN
    logic p1, p2;

    // Parity is formed at stage-1 capture and travels with its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            if (adv2 && v1)      p2 <= p1;
            if (adv1 && in_valid) p1 <= ^mux_word;
        end
    end

    assign out_parity = p2;
`endif

endmodule

// File: tb/tb_act_mux_pipe.sv
// Directed and scoreboard checks for act_mux_pipe at default parameters.
// Define ACT_MUX_PARITY_EN to also check the parity output.
module tb_act_mux_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_a;
    logic [1:0]  in_b;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef ACT_MUX_PARITY_EN
    logic        out_parity;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    act_mux_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef ACT_MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference select for GATE_MASK=2'b10: S1 = A1|B1, S0 = A0&B0.
    function automatic logic [7:0] model(input logic [1:0] a, input logic [1:0] b,
                                         input logic [31:0] d);
        logic s1, s0;
        s1 = a[1] | b[1];
        s0 = a[0] & b[0];
        case ({s1, s0})
            2'b00:   return d[7:0];
            2'b01:   return d[15:8];
            2'b10:   return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    // Expected word for combo c = {A1,B1,A0,B0}, data words {0x11,0x22,0x33,0x44}.
    logic [7:0] c2_exp [16] = '{8'h11, 8'h11, 8'h11, 8'h22,
                                8'h33, 8'h33, 8'h33, 8'h44,
                                8'h33, 8'h33, 8'h33, 8'h44,
                                8'h33, 8'h33, 8'h33, 8'h44};

    task automatic send_word(input logic [7:0] w);
        in_data  = {4{w}};
        in_a     = 2'b00;
        in_b     = 2'b00;
        in_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_w;
        logic [7:0] prev_data;
        logic       prev_stall;
        int         sent, recv, cnt, cyc;

        rst_n     = 1'b0;
        in_data   = '0;
        in_a      = '0;
        in_b      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
`ifdef ACT_MUX_PARITY_EN
        check("rst_parity", 32'(out_parity), 32'd0);
`endif
        rst_n = 1'b1;

        // C2 equivalence: all 16 gate combinations back-to-back, 2-cycle latency.
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c < 16) begin
                in_data  = 32'h44332211;
                in_a     = {c[3], c[1]};
                in_b     = {c[2], c[0]};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("c2_ready", 32'(in_ready), 32'd1);
            if (c >= 2) begin
                check($sformatf("c2_valid%0d", c - 2), 32'(out_valid), 32'd1);
                check($sformatf("c2_data%0d", c - 2), 32'(out_data), 32'(c2_exp[c-2]));
            end else begin
                check("c2_empty", 32'(out_valid), 32'd0);
            end
        end
        @(negedge clk);
        check("c2_drained", 32'(out_valid), 32'd0);

        // Back-pressure: 0x01, 0x02 fill the pipe; 0x03 waits until release.
        out_ready = 1'b0;
        send_word(8'h01);
        #1 check("bp_ready0", 32'(in_ready), 32'd1);
        @(negedge clk);
        send_word(8'h02);
        #1 check("bp_ready1", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            send_word(8'h03);
            #1;
            check("bp_ready_low", 32'(in_ready),  32'd0);
            check("bp_valid",     32'(out_valid), 32'd1);
            check("bp_hold",      32'(out_data),  32'h01);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        check("bp_out1",      32'(out_data), 32'h01);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bp_out2", 32'(out_data), 32'h02);
        check("bp_v2", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1 check("bp_out3", 32'(out_data), 32'h03);
        check("bp_v3", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1 check("bp_empty", 32'(out_valid), 32'd0);

        // Full throughput: 100 words in, 100 out, out_valid unbroken from cycle 2.
        cnt = 0;
        for (int c = 0; c < 102; c++) begin
            @(negedge clk);
            if (c < 100) send_word(8'(c));
            else         in_valid = 1'b0;
            #1;
            if (c >= 2) begin
                check("ft_valid", 32'(out_valid), 32'd1);
                check("ft_data",  32'(out_data),  32'(8'(c - 2)));
            end else begin
                check("ft_lead", 32'(out_valid), 32'd0);
            end
            if (out_valid && out_ready) cnt++;
        end
        check("ft_count", 32'(cnt), 32'd100);

`ifdef ACT_MUX_PARITY_EN
        // Parity travels with its word: 0x07 odd weight, 0x03 even.
        @(negedge clk);
        send_word(8'h07);
        @(negedge clk);
        send_word(8'h03);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("par_d07", 32'(out_data),   32'h07);
        check("par_07",  32'(out_parity), 32'd1);
        @(negedge clk);
        #1;
        check("par_d03", 32'(out_data),   32'h03);
        check("par_03",  32'(out_parity), 32'd0);
`endif

        // Mid-stream reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        send_word(8'hA5);
        @(negedge clk);
        send_word(8'h5A);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("mr_full", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data",  32'(out_data),  32'd0);
        check("mr_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        check("mr_valid_edge", 32'(out_valid), 32'd0);
`ifdef ACT_MUX_PARITY_EN
        check("mr_parity", 32'(out_parity), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against a queue model.
        sent = 0;
        recv = 0;
        cyc  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (recv < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_data   = $urandom;
            in_a      = 2'($urandom_range(0, 3));
            in_b      = 2'($urandom_range(0, 3));
            in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) check("rnd_stall_hold", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_underflow", 32'd1, 32'd0);
                end else begin
                    exp_w = q.pop_front();
                    check("rnd_data", 32'(out_data), 32'(exp_w));
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_data));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        check("rnd_recv",  32'(recv),     32'd1000);
        check("rnd_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
